program_sequencer: RTL and testbench

Reader/executor for the 8-entry instruction memory that the switch-driven memory system fills. The block steps a program counter through addresses 0..7 and fetches each 15-bit word {instr[2:0], A[5:0], B[5:0]}. It presents the fields to the ALU, then latches the ALU result with its address for the seven-segment displays. Steps come from a pushbutton, one per press, or from an internal tick in auto-run mode.

---
 rtl/program_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_program_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer
//  Description : Steps a 3-bit program counter through an 8-word instruction
//                memory. It fetches each word, presents its fields to an
//                external ALU, and latches the ALU result with its address.
//                Steps come from a debounced pushbutton or from an auto-run
//                tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned LOCKOUT  = 500000,
   parameter bit          WRAP     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key,
   input  logic        run,
   input  logic [14:0] rd_data,
   input  logic [5:0]  C,
   output logic        rd_en,
   output logic [2:0]  rd_addr,
   output logic [2:0]  instr,
   output logic [5:0]  A,
   output logic [5:0]  B,
   output logic [5:0]  result,
   output logic [2:0]  res_addr,
   output logic        res_valid,
   output logic        busy,
   output logic        done
);

   localparam int unsigned TICK_W    = $clog2(TICK_DIV);
   localparam int unsigned LOCK_W    = (LOCKOUT > 2) ? $clog2(LOCKOUT) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'((LOCKOUT == 0) ? 0 : LOCKOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q,     state_d;
   logic [2:0]          pc_q,        pc_d;
   logic [2:0]          instr_q,     instr_d;
   logic [5:0]          a_q,         a_d;
   logic [5:0]          b_q,         b_d;
   logic [5:0]          result_q,    result_d;
   logic [2:0]          res_addr_q,  res_addr_d;
   logic                res_valid_q, res_valid_d;
   logic                rd_en_q,     rd_en_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic [TICK_W-1:0]   tick_cnt_q,  tick_cnt_d;
   logic [LOCK_W-1:0]   lockout_q,   lockout_d;
   logic                key_meta_q,  key_meta_d;
   logic                key_sync_q,  key_sync_d;
   logic                key_prev_q,  key_prev_d;

   logic                key_fall;
   logic                press;
   logic                tick;
   logic                step;

   // Next-state logic: key conditioning, auto tick, and the fetch/execute FSM
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      res_addr_d  = res_addr_q;
      res_valid_d = res_valid_q;
      tick_cnt_d  = tick_cnt_q;
      lockout_d   = lockout_q;
      tick        = 1'b0;

      // Two-flop synchronizer followed by a third flop for edge detection
      key_meta_d  = key;
      key_sync_d  = key_meta_q;
      key_prev_d  = key_sync_q;
      key_fall    = key_prev_q & ~key_sync_q;

      // Debounce: only the first fall outside the lockout window counts
      press = key_fall && (lockout_q == '0) && !run;
      if (press) begin
         lockout_d = LOCK_LOAD;
      end else if (lockout_q != '0) begin
         lockout_d = lockout_q - 1'b1;
      end

      // Auto-run divider; parked at zero while single-stepping
      if (!run) begin
         tick_cnt_d = '0;
      end else if (tick_cnt_q == TICK_LAST) begin
         tick_cnt_d = '0;
         tick       = 1'b1;
      end else begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end

      step = press | tick;

      case (state_q)
         S_IDLE: begin
            if (step) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            instr_d = rd_data[14:12];
            a_d     = rd_data[11:6];
            b_d     = rd_data[5:0];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            result_d    = C;
            res_addr_d  = pc_q;
            res_valid_d = 1'b1;
            if ((pc_q == 3'd7) && !WRAP) begin
               state_d = S_DONE;
            end else begin
               pc_d    = pc_q + 3'd1;
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered from the upcoming state
      rd_en_d = (state_d == S_FETCH);
      busy_d  = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_EXEC);
      done_d  = (state_d == S_DONE);
   end

   // State register; reset aborts any in-flight word and releases the key path
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= 3'd0;
         instr_q     <= 3'd0;
         a_q         <= 6'd0;
         b_q         <= 6'd0;
         result_q    <= 6'd0;
         res_addr_q  <= 3'd0;
         res_valid_q <= 1'b0;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tick_cnt_q  <= '0;
         lockout_q   <= '0;
         key_meta_q  <= 1'b1;
         key_sync_q  <= 1'b1;
         key_prev_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         res_addr_q  <= res_addr_d;
         res_valid_q <= res_valid_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tick_cnt_q  <= tick_cnt_d;
         lockout_q   <= lockout_d;
         key_meta_q  <= key_meta_d;
         key_sync_q  <= key_sync_d;
         key_prev_q  <= key_prev_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_addr   = pc_q;
   assign instr     = instr_q;
   assign A         = a_q;
   assign B         = b_q;
   assign result    = result_q;
   assign res_addr  = res_addr_q;
   assign res_valid = res_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_sequencer
//  Description : Bench for program_sequencer with a wrapping and a stopping
//                instance, a behavioural memory and ALU, and a program-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        key;
   logic        run;

   logic [14:0] rd_data1, rd_data0;
   logic [5:0]  C1, C0;
   logic        rd_en1, rd_en0;
   logic [2:0]  rd_addr1, rd_addr0;
   logic [2:0]  instr1, instr0;
   logic [5:0]  A1, A0, B1, B0;
   logic [5:0]  result1, result0;
   logic [2:0]  res_addr1, res_addr0;
   logic        res_valid1, res_valid0;
   logic        busy1, busy0;
   logic        done1, done0;

   logic [14:0] mem [8];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fetch1   = 0;
   int fetch0   = 0;
   int last_addr1 = -1;

   // Reference model state (wrapping instance)
   logic [2:0] exp_pc;
   logic [2:0] exp_instr;
   logic [5:0] exp_a, exp_b, exp_res;
   logic [2:0] exp_addr;
   logic       exp_valid;

   always #5 clk = ~clk;

   function automatic logic [5:0] alu(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b);
      case (op)
         3'd1:    return a + b;
         3'd2:    return a - b;
         3'd3:    return a & b;
         3'd4:    return a ^ b;
         default: return a | b;
      endcase
   endfunction

   assign C1 = alu(instr1, A1, B1);
   assign C0 = alu(instr0, A0, B0);

   program_sequencer #(.TICK_DIV(4), .LOCKOUT(50), .WRAP(1'b1)) dut1 (
      .clk(clk), .rst(rst), .key(key), .run(run), .rd_data(rd_data1), .C(C1),
      .rd_en(rd_en1), .rd_addr(rd_addr1), .instr(instr1), .A(A1), .B(B1),
      .result(result1), .res_addr(res_addr1), .res_valid(res_valid1),
      .busy(busy1), .done(done1)
   );

   program_sequencer #(.TICK_DIV(4), .LOCKOUT(50), .WRAP(1'b0)) dut0 (
      .clk(clk), .rst(rst), .key(key), .run(run), .rd_data(rd_data0), .C(C0),
      .rd_en(rd_en0), .rd_addr(rd_addr0), .instr(instr0), .A(A0), .B(B0),
      .result(result0), .res_addr(res_addr0), .res_valid(res_valid0),
      .busy(busy0), .done(done0)
   );

   // Synchronous-read instruction memory shared by both instances
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en1) rd_data1 <= mem[rd_addr1];
      if (rd_en0) rd_data0 <= mem[rd_addr0];
   end

   // Fetch counters
   always @(negedge clk) begin
      if (rd_en1) begin
         fetch1     = fetch1 + 1;
         last_addr1 = int'(rd_addr1);
      end
      if (rd_en0) fetch0 = fetch0 + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_pc = 3'd0; exp_instr = 3'd0; exp_a = 6'd0; exp_b = 6'd0;
      exp_res = 6'd0; exp_addr = 3'd0; exp_valid = 1'b0;
   endtask

   // One executed word: read memory at pc, evaluate, advance pc mod 8
   task automatic model_exec();
      logic [14:0] w;
      w         = mem[exp_pc];
      exp_instr = w[14:12];
      exp_a     = w[11:6];
      exp_b     = w[5:0];
      exp_res   = alu(exp_instr, exp_a, exp_b);
      exp_addr  = exp_pc;
      exp_valid = 1'b1;
      exp_pc    = exp_pc + 3'd1;
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, "_pc"},        int'(rd_addr1),   int'(exp_pc));
      check_eq({tag, "_instr"},     int'(instr1),     int'(exp_instr));
      check_eq({tag, "_A"},         int'(A1),         int'(exp_a));
      check_eq({tag, "_B"},         int'(B1),         int'(exp_b));
      check_eq({tag, "_result"},    int'(result1),    int'(exp_res));
      check_eq({tag, "_res_addr"},  int'(res_addr1),  int'(exp_addr));
      check_eq({tag, "_res_valid"}, int'(res_valid1), int'(exp_valid));
      check_eq({tag, "_busy"},      int'(busy1),      0);
   endtask

   // Press with optional contact bounce, then idle past the lockout window
   task automatic press(input int bounces, input int hold);
      @(negedge clk);
      for (int i = 0; i < bounces; i++) begin
         key = 1'b0;
         repeat ($urandom_range(1, 2)) @(negedge clk);
         key = 1'b1;
         repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      key = 1'b0;
      repeat (hold) @(negedge clk);
      key = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   task automatic wait_fetch(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rd_en1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_rd_en"},     int'(rd_en1),     0);
      check_eq({tag, "_rd_addr"},   int'(rd_addr1),   0);
      check_eq({tag, "_instr"},     int'(instr1),     0);
      check_eq({tag, "_A"},         int'(A1),         0);
      check_eq({tag, "_B"},         int'(B1),         0);
      check_eq({tag, "_result"},    int'(result1),    0);
      check_eq({tag, "_res_addr"},  int'(res_addr1),  0);
      check_eq({tag, "_res_valid"}, int'(res_valid1), 0);
      check_eq({tag, "_busy"},      int'(busy1),      0);
      check_eq({tag, "_done"},      int'(done1),      0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int f1, f0, prev_cyc;
      bit ok;

      rst = 1'b1; key = 1'b1; run = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 15'd0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      check_eq("reset_done0", int'(done0), 0);
      rst = 1'b0;
      model_reset();

      // Directed first word: add 5 + 3 at address 0
      mem[0] = 15'b001_000101_000011;
      f1 = fetch1;
      press(0, 20);
      check_eq("t1_fetches", fetch1 - f1, 1);
      check_eq("t1_fetch_addr", last_addr1, 0);
      model_exec();
      check_all("t1");
      check_eq("t1_result_const", int'(result1), 8);

      // Bounced press then a clean press
      for (int i = 1; i < 8; i++) mem[i] = 15'($urandom);
      f1 = fetch1;
      press(5, 20);
      check_eq("bounce_fetches", fetch1 - f1, 1);
      model_exec();
      check_all("bounce");
      f1 = fetch1;
      press(0, 20);
      check_eq("clean_fetches", fetch1 - f1, 1);
      model_exec();
      check_all("clean");

      // Randomized presses over random program contents
      for (int i = 0; i < 8; i++) mem[i] = 15'($urandom);
      for (int n = 0; n < 10; n++) begin
         f1 = fetch1;
         press($urandom_range(0, 5), $urandom_range(4, 20));
         check_eq("rand_fetches", fetch1 - f1, 1);
         model_exec();
         check_all("rand");
      end

      // Reset asserted during the memory-wait cycle
      @(negedge clk);
      key = 1'b0;
      wait_fetch(ok);
      check_eq("rstwait_fetch_seen", int'(ok), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      key = 1'b1;
      #1;
      check_zero("rstwait");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      f1 = fetch1;
      press(0, 20);
      check_eq("rstwait_fetches", fetch1 - f1, 1);
      check_eq("rstwait_fetch_addr", last_addr1, 0);
      model_exec();
      check_all("rstwait_after");

      // Auto-run with a counting program; stopping instance must halt after 7
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) mem[i] = {3'd1, 6'(i), 6'(i)};
      f0 = fetch0;
      run = 1'b1;
      prev_cyc = 0;
      for (int k = 0; k < 9; k++) begin
         wait_fetch(ok);
         check_eq("run_fetch_seen", int'(ok), 1);
         check_eq("run_rd_addr", int'(rd_addr1), k % 8);
         check_eq("run_busy", int'(busy1), 1);
         check_eq("run_rd_en0", int'(rd_en0), (k < 8) ? 1 : 0);
         if (k > 0) check_eq("run_period", cyc - prev_cyc, 4);
         prev_cyc = cyc;
         for (int j = 0; j < 3; j++) begin
            key = (k < 6) ? 1'($urandom) : 1'b1;
            @(negedge clk);
         end
         check_eq("run_result", int'(result1), 2 * (k % 8));
         check_eq("run_res_addr", int'(res_addr1), k % 8);
         if (k == 7) begin
            check_eq("wrap0_done", int'(done0), 1);
            check_eq("wrap0_busy", int'(busy0), 0);
         end
         if (k == 8) run = 1'b0;
         model_exec();
      end
      check_eq("wrap0_fetches", fetch0 - f0, 8);
      check_eq("wrap0_result", int'(result0), 14);
      check_eq("wrap0_res_addr", int'(res_addr0), 7);

      // Ninth press: stopping instance ignores it, wrapping one proceeds
      f0 = fetch0;
      f1 = fetch1;
      press(0, 20);
      check_eq("ninth_fetches0", fetch0 - f0, 0);
      check_eq("ninth_result0", int'(result0), 14);
      check_eq("ninth_done0", int'(done0), 1);
      check_eq("ninth_fetches1", fetch1 - f1, 1);
      model_exec();
      check_all("ninth");

      // Press and run toggle arriving together: exactly one step
      f1 = fetch1;
      @(negedge clk);
      key = 1'b0;
      run = 1'b1;
      repeat (4) @(negedge clk);
      run = 1'b0;
      repeat (16) @(negedge clk);
      key = 1'b1;
      repeat (60) @(negedge clk);
      check_eq("coinc_fetches", fetch1 - f1, 1);
      model_exec();
      check_all("coinc");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
